multi_cycle_control: RTL and testbench

- Main control FSM of the multi-cycle CPU, instantiated in cpu_top as u_control.
- Sequences every instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the datapath enables and mux selects, and raises exceptions: illegal instruction (Cause=1) and misaligned address (Cause=2).
- Asserts a sticky Halt, which the testbench polls to end simulation.

---
 rtl/multi_cycle_control.sv | 223 ++++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// ---------------------------------------------------------------------------
// multi_cycle_control
//   Main control FSM of the multi-cycle CPU. It steps every instruction
//   through fetch, decode, execute, memory and writeback cycles. Each state
//   lasts one cycle. The FSM drives the datapath enables and mux selects. It
//   raises the illegal-instruction exception (Cause=1) and the
//   misaligned-address exception (Cause=2), and it holds a sticky Halt.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   opcode/funct3/...   instruction fields from the IR
//   alu_zero            ALU zero flag (combined with PCWriteCond outside)
//   addr_misaligned     ALUOut address not aligned to the access size
//   PCWrite..PCSource   datapath enables and mux selects (Moore decodes)
//   CauseWrite, Cause   cause register load and value
//   Halt                sticky halt, set on entry to HALT
//   instr_retired       count of completed instructions
// ---------------------------------------------------------------------------
module multi_cycle_control #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0100,
    parameter logic [4:0]  LINK_REG   = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        alu_zero,
    input  logic        addr_misaligned,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDstLink,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        CauseWrite,
    output logic [31:0] Cause,
    output logic        Halt,
    output logic [31:0] instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_LUI      = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_CHK  = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JAL      = 4'd12,
        S_EXCEPT   = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    state_t     state;
    logic [1:0] cause_q;
    logic       halt_q;

    // Raw strobes before the reset mask.
    logic pcw_r, pcwc_r, mr_r, mw_r, irw_r, rw_r, cw_r;

    // These fields are consumed by the datapath, not by the sequencer. The
    // signal exists only so that they are referenced.
    logic unused_ok;
    assign unused_ok = ^{funct3, funct7_5, alu_zero, EXC_VECTOR, LINK_REG};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_FETCH;
            halt_q        <= 1'b0;
            cause_q       <= 2'd0;
            instr_retired <= 32'd0;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        7'h33:        state <= S_EXEC_R;
                        7'h13:        state <= S_EXEC_I;
                        7'h03, 7'h23: state <= S_MEM_ADDR;
                        7'h63:        state <= S_BRANCH;
                        7'h6F:        state <= S_JAL;
                        7'h37:        state <= S_LUI;
                        7'h73: begin
                            state  <= S_HALT;
                            halt_q <= 1'b1;   // visible from the first HALT cycle
                        end
                        default: begin
                            state   <= S_EXCEPT;
                            cause_q <= 2'd1;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I, S_LUI: state <= S_ALU_WB;
                S_MEM_ADDR: state <= S_MEM_CHK;
                // The alignment flag is only meaningful one cycle after the
                // address reaches ALUOut, so it is checked here.
                S_MEM_CHK: begin
                    if (addr_misaligned) begin
                        state   <= S_EXCEPT;
                        cause_q <= 2'd2;
                    end else if (opcode == 7'h03) begin
                        state <= S_MEM_RD;
                    end else begin
                        state <= S_MEM_WR;
                    end
                end
                S_MEM_RD: state <= S_MEM_WB;
                // Completing states: the instruction retires on the way back
                // to FETCH.
                S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL: begin
                    state         <= S_FETCH;
                    instr_retired <= instr_retired + 32'd1;
                end
                S_EXCEPT: state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pcw_r      = 1'b0;
        pcwc_r     = 1'b0;
        mr_r       = 1'b0;
        mw_r       = 1'b0;
        irw_r      = 1'b0;
        rw_r       = 1'b0;
        cw_r       = 1'b0;
        IorD       = 1'b0;
        RegDstLink = 1'b0;
        MemtoReg   = 2'd0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ALUOp      = 2'd0;
        PCSource   = 2'd0;
        case (state)
            S_FETCH: begin
                mr_r    = 1'b1;
                irw_r   = 1'b1;
                pcw_r   = 1'b1;
                ALUSrcB = 2'd1;
            end
            S_DECODE:   ALUSrcB = 2'd2;
            S_EXEC_R: begin
                ALUSrcA = 2'd1;
                ALUOp   = 2'd2;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ALUOp   = 2'd2;
            end
            S_ALU_WB:   rw_r = 1'b1;
            S_LUI: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd2;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
            end
            S_MEM_RD: begin
                mr_r = 1'b1;
                IorD = 1'b1;
            end
            S_MEM_WB: begin
                rw_r     = 1'b1;
                MemtoReg = 2'd1;
            end
            S_MEM_WR: begin
                mw_r = 1'b1;
                IorD = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 2'd1;
                ALUOp    = 2'd1;
                pcwc_r   = 1'b1;
                PCSource = 2'd1;
            end
            S_JAL: begin
                rw_r     = 1'b1;
                MemtoReg = 2'd2;
                pcw_r    = 1'b1;
                PCSource = 2'd1;
            end
            S_EXCEPT: begin
                rw_r       = 1'b1;
                RegDstLink = 1'b1;
                MemtoReg   = 2'd2;
                cw_r       = 1'b1;
                pcw_r      = 1'b1;
                PCSource   = 2'd2;
            end
            default: ;
        endcase
    end

    // Reset gates every write and strobe in the same cycle. This stops an
    // interrupted instruction from writing memory or the register file.
    assign PCWrite     = pcw_r  & ~reset;
    assign PCWriteCond = pcwc_r & ~reset;
    assign MemRead     = mr_r   & ~reset;
    assign MemWrite    = mw_r   & ~reset;
    assign IRWrite     = irw_r  & ~reset;
    assign RegWrite    = rw_r   & ~reset;
    assign CauseWrite  = cw_r   & ~reset;
    assign Cause       = {30'd0, cause_q};
    assign Halt        = halt_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7_5 = 1'b0;
    logic        alu_zero = 1'b0;
    logic        addr_misaligned = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        RegWrite, RegDstLink, CauseWrite, Halt;
    logic [1:0]  MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource;
    logic [31:0] Cause, instr_retired;

    multi_cycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .alu_zero(alu_zero),
        .addr_misaligned(addr_misaligned),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDstLink(RegDstLink), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .CauseWrite(CauseWrite), .Cause(Cause),
        .Halt(Halt), .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int model_retired = 0;

    // Output bundle: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    // RegWrite, RegDstLink, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, CauseWrite}
    function automatic logic [18:0] ov(input logic pcw, pcwc, iord, mr, mw, irw,
                                       rw, rdl, input logic [1:0] m2r, sa, sb,
                                       aop, pcs, input logic cw);
        return {pcw, pcwc, iord, mr, mw, irw, rw, rdl, m2r, sa, sb, aop, pcs, cw};
    endfunction

    function automatic logic [18:0] dut_ov();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                RegDstLink, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, CauseWrite};
    endfunction

    logic [18:0] V_F, V_D, V_ER, V_EI, V_WB, V_LU, V_MA, V_MC, V_RD, V_MW,
                 V_WR, V_BR, V_J, V_EX, V_H, V_RST;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: what each instruction class does cycle by cycle.
    logic [18:0] exp_q[$];
    bit          exp_ret;
    logic [31:0] exp_cause;

    task automatic build_expect(input logic [6:0] op, input logic mis);
        exp_q.delete();
        exp_q.push_back(V_F);
        exp_q.push_back(V_D);
        exp_ret   = 1'b1;
        exp_cause = 32'd0;
        case (op)
            7'h33: begin exp_q.push_back(V_ER); exp_q.push_back(V_WB); end
            7'h13: begin exp_q.push_back(V_EI); exp_q.push_back(V_WB); end
            7'h37: begin exp_q.push_back(V_LU); exp_q.push_back(V_WB); end
            7'h03, 7'h23: begin
                exp_q.push_back(V_MA);
                exp_q.push_back(V_MC);
                if (mis) begin
                    exp_q.push_back(V_EX);
                    exp_ret = 1'b0;
                    exp_cause = 32'd2;
                end else if (op == 7'h03) begin
                    exp_q.push_back(V_RD);
                    exp_q.push_back(V_MW);
                end else begin
                    exp_q.push_back(V_WR);
                end
            end
            7'h63: exp_q.push_back(V_BR);
            7'h6F: exp_q.push_back(V_J);
            7'h73: begin exp_q.push_back(V_H); exp_ret = 1'b0; end
            default: begin
                exp_q.push_back(V_EX);
                exp_ret = 1'b0;
                exp_cause = 32'd1;
            end
        endcase
    endtask

    task automatic drive(input logic [6:0] op, input logic mis);
        opcode          = op;
        addr_misaligned = mis;
        funct3          = 3'($urandom);
        funct7_5        = 1'($urandom);
        alu_zero        = 1'($urandom);
    endtask

    // Entry: sampled in a FETCH cycle. Exit: sampled in the next FETCH cycle.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic mis);
        build_expect(op, mis);
        chk({tag, ".retired"}, instr_retired, model_retired);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                @(negedge clk);
                drive(op, mis);
                #1;
            end
            chk($sformatf("%s.cyc%0d", tag, i + 1), 32'(dut_ov()), 32'(exp_q[i]));
            if (exp_q[i] == V_EX)
                chk({tag, ".cause"}, Cause, exp_cause);
        end
        if (exp_ret) model_retired++;
        @(negedge clk);
        drive(op, mis);
        #1;
    endtask

    typedef struct {
        logic [6:0] op;
        logic       mis;
        int         lat;
        int         ret;
        int         exc_cyc;
        int         cause;
        bit         mw;
    } vec_t;
    vec_t tbl[11];

    initial begin
        int lat, exc_cyc, cause_seen, start_ret;
        bit mw_seen;
        logic [6:0] legal[7];

        V_F   = ov(1,0,0,1,0,1,0,0, 0,0,1,0,0, 0);
        V_D   = ov(0,0,0,0,0,0,0,0, 0,0,2,0,0, 0);
        V_ER  = ov(0,0,0,0,0,0,0,0, 0,1,0,2,0, 0);
        V_EI  = ov(0,0,0,0,0,0,0,0, 0,1,2,2,0, 0);
        V_WB  = ov(0,0,0,0,0,0,1,0, 0,0,0,0,0, 0);
        V_LU  = ov(0,0,0,0,0,0,0,0, 0,2,2,0,0, 0);
        V_MA  = ov(0,0,0,0,0,0,0,0, 0,1,2,0,0, 0);
        V_MC  = ov(0,0,0,0,0,0,0,0, 0,0,0,0,0, 0);
        V_RD  = ov(0,0,1,1,0,0,0,0, 0,0,0,0,0, 0);
        V_MW  = ov(0,0,0,0,0,0,1,0, 1,0,0,0,0, 0);
        V_WR  = ov(0,0,1,0,1,0,0,0, 0,0,0,0,0, 0);
        V_BR  = ov(0,1,0,0,0,0,0,0, 0,1,0,1,1, 0);
        V_J   = ov(1,0,0,0,0,0,1,0, 2,0,0,0,1, 0);
        V_EX  = ov(1,0,0,0,0,0,1,1, 2,0,0,0,2, 1);
        V_H   = ov(0,0,0,0,0,0,0,0, 0,0,0,0,0, 0);
        V_RST = ov(0,0,0,0,0,0,0,0, 0,0,1,0,0, 0);   // FETCH with strobes masked

        //          op     mis lat ret exc cause mw
        tbl[0]  = '{7'h33, 0, 4, 1, 0, 0, 0};
        tbl[1]  = '{7'h13, 0, 4, 1, 0, 0, 0};
        tbl[2]  = '{7'h37, 0, 4, 1, 0, 0, 0};
        tbl[3]  = '{7'h03, 0, 6, 1, 0, 0, 0};
        tbl[4]  = '{7'h23, 0, 5, 1, 0, 0, 1};
        tbl[5]  = '{7'h63, 0, 3, 1, 0, 0, 0};
        tbl[6]  = '{7'h6F, 0, 3, 1, 0, 0, 0};
        tbl[7]  = '{7'h7F, 0, 3, 0, 3, 1, 0};
        tbl[8]  = '{7'h00, 0, 3, 0, 3, 1, 0};
        tbl[9]  = '{7'h03, 1, 5, 0, 5, 2, 0};
        tbl[10] = '{7'h23, 1, 5, 0, 5, 2, 0};

        legal = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F};

        // Reset for two cycles.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        chk("rst.outputs", 32'(dut_ov()), 32'(V_RST));
        @(negedge clk); reset = 1'b0; #1;
        chk("rst.halt", 32'(Halt), 32'd0);
        chk("rst.retired", instr_retired, 32'd0);
        chk("rst.fetch", 32'(dut_ov()), 32'(V_F));

        // Hand-written sequences from the test plan.
        run_instr("addi", 7'h13, 1'b0);
        chk("addi.retired1", instr_retired, 32'd1);
        run_instr("load", 7'h03, 1'b0);
        run_instr("st_mis", 7'h23, 1'b1);
        run_instr("illegal", 7'h7F, 1'b0);
        run_instr("rtype", 7'h33, 1'b0);
        run_instr("beq", 7'h63, 1'b0);
        run_instr("jal", 7'h6F, 1'b0);

        // Table: latency, retire count, exception timing and cause, store strobe.
        foreach (tbl[k]) begin
            start_ret = instr_retired;
            lat = 0; exc_cyc = 0; cause_seen = 0; mw_seen = 0;
            do begin
                @(negedge clk);
                drive(tbl[k].op, tbl[k].mis);
                #1;
                lat++;
                if (MemWrite) mw_seen = 1;
                if (CauseWrite) begin
                    exc_cyc = lat + 1;
                    cause_seen = Cause;
                end
            end while (!IRWrite && lat < 20);
            chk($sformatf("tbl%0d.latency", k), lat, tbl[k].lat);
            chk($sformatf("tbl%0d.retire", k), instr_retired - start_ret, tbl[k].ret);
            chk($sformatf("tbl%0d.exc_cycle", k), exc_cyc, tbl[k].exc_cyc);
            chk($sformatf("tbl%0d.cause", k), cause_seen, tbl[k].cause);
            chk($sformatf("tbl%0d.memwrite", k), 32'(mw_seen), 32'(tbl[k].mw));
            model_retired += tbl[k].ret;
        end

        // Random instruction mix against the model.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            if ($urandom_range(0, 9) < 7) op = legal[$urandom_range(0, 6)];
            else op = 7'($urandom);
            if (op == 7'h73) op = 7'h7F;
            run_instr($sformatf("rnd%0d", n), op, 1'($urandom));
        end
        chk("rnd.retired", instr_retired, model_retired);

        // Reset landing in MEM_WR suppresses the write.
        @(negedge clk); drive(7'h23, 1'b0);            // DECODE
        @(negedge clk); drive(7'h23, 1'b0);            // MEM_ADDR
        @(negedge clk); drive(7'h23, 1'b0);            // MEM_CHK
        @(negedge clk); drive(7'h23, 1'b0); reset = 1'b1; #1;
        chk("rstwr.in_memwr", 32'(IorD), 32'd1);
        chk("rstwr.memwrite", 32'(MemWrite), 32'd0);
        @(negedge clk); reset = 1'b0; #1;
        chk("rstwr.fetch", 32'(dut_ov()), 32'(V_F));
        chk("rstwr.retired", instr_retired, 32'd0);
        model_retired = 0;

        // Halt is sticky until reset.
        @(negedge clk); drive(7'h73, 1'b0); #1;
        chk("halt.decode", 32'(Halt), 32'd0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            drive(7'($urandom), 1'($urandom));
            #1;
            chk($sformatf("halt.c%0d", c), 32'(Halt), 32'd1);
            if (c % 20 == 0) chk($sformatf("halt.out%0d", c), 32'(dut_ov()), 32'(V_H));
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        chk("halt.cleared", 32'(Halt), 32'd0);
        chk("halt.fetch", 32'(dut_ov()), 32'(V_F));
        chk("halt.retired", instr_retired, 32'd0);
        run_instr("after_halt", 7'h13, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
